stoch_signed_sng: RTL and testbench

- Signed-channel stochastic number generator: converts a two's-complement fixed-point value into a pair of unipolar bitstreams (y_p, y_m).
- Exactly one channel carries the magnitude; the other is held at 0.
- Sits directly upstream of the signed stochastic arithmetic stages (sub, max, etc.) and feeds their a_p/a_m or b_p/b_m inputs.
- Output is exact over one LFSR period: the ones-count equals the held magnitude.

---
 rtl/stoch_signed_sng_if.sv | 29 ++
 rtl/stoch_signed_sng.sv | 100 ++++++++++
 tb/tb_stoch_signed_sng.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/stoch_signed_sng_if.sv
// Stream-side bundle for stoch_signed_sng.
//   master: drives en / load / value, observes y_p / y_m / period_done
//   slave : the generator itself
// Ports carried:
//   en          advance enable (stream pauses when low)
//   load        capture value this cycle
//   value       signed two's-complement input, value/2^(BITWIDTH-1)
//   y_p, y_m    positive / negative channel bitstreams
//   period_done one-cycle pulse on the last bit of each LFSR period
interface stoch_signed_sng_if #(
  parameter int BITWIDTH = 8
);
  logic                       en;
  logic                       load;
  logic signed [BITWIDTH-1:0] value;
  logic                       y_p;
  logic                       y_m;
  logic                       period_done;

  modport master (
    output en, load, value,
    input  y_p, y_m, period_done
  );

  modport slave (
    input  en, load, value,
    output y_p, y_m, period_done
  );
endinterface

// File: rtl/stoch_signed_sng.sv
// Signed-channel stochastic number generator.
// Converts a two's-complement fixed-point value into a pair of unipolar
// bitstreams: the magnitude is emitted on y_p (value >= 0) or y_m
// (value < 0), the other channel stays 0. Over one full LFSR period of
// P = 2^L - 1 enabled cycles the active channel carries exactly |value|
// ones, where L = BITWIDTH-1.
//
// Parameters:
//   BITWIDTH  8 or 16 (anything else stops elaboration)
//   SEED      LFSR start / reseed state; 0 is mapped to 1
// Ports:
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   stoch_signed_sng_if.slave (en, load, value, y_p, y_m, period_done)
// Build option:
//   STOCH_SNG_RESEED_ON_LOAD_EN  when defined, load also restarts the LFSR
//   at SEED and the period counter at 0, so the following P enabled cycles
//   form an aligned exact period.
module stoch_signed_sng #(
  parameter int BITWIDTH = 8,
  parameter int SEED     = 1
) (
  input  logic               CLK,
  input  logic               nRST,
  stoch_signed_sng_if.slave  bus
);

  localparam int L = BITWIDTH - 1;

  localparam logic [L-1:0]              SEED_L   = L'(SEED);
  localparam logic [L-1:0]              SEED_EFF = (SEED_L == '0) ? L'(1) : SEED_L;
  // Last count of the period: P-1 = 2^L - 2
  localparam logic [L-1:0]              CNT_LAST = {{(L-1){1'b1}}, 1'b0};
  localparam logic signed [BITWIDTH-1:0] VAL_MIN = {1'b1, {L{1'b0}}};

  generate
    if (!(BITWIDTH == 8 || BITWIDTH == 16)) begin : g_bad_width
      $error("stoch_signed_sng: BITWIDTH must be 8 or 16");
    end
  endgenerate

  // |v| clipped to L bits; the most negative code has no positive twin,
  // so it saturates to the all-ones magnitude.
  function automatic logic [L-1:0] sat_mag(input logic signed [BITWIDTH-1:0] v);
    logic [L-1:0] mag;
    mag = v[L-1:0];
    if (v == VAL_MIN) begin
      mag = '1;
    end else if (v < 0) begin
      mag = L'(-v);
    end
    return mag;
  endfunction

  logic         val_sign;
  logic [L-1:0] val_mag;
  logic [L-1:0] lfsr;
  logic [L-1:0] cnt;
  logic         lfsr_fb;
  logic         hit;

  // x^L + x^(L-1) + 1 is primitive for L = 7 and L = 15
  assign lfsr_fb = lfsr[L-1] ^ lfsr[L-2];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      val_sign <= 1'b0;
      val_mag  <= '0;
      lfsr     <= SEED_EFF;
      cnt      <= '0;
    end else begin
      if (bus.load) begin
        val_sign <= bus.value[BITWIDTH-1];
        val_mag  <= sat_mag(bus.value);
      end
`ifdef STOCH_SNG_RESEED_ON_LOAD_EN
      if (bus.load) begin
        lfsr <= SEED_EFF;
        cnt  <= '0;
      end else if (bus.en) begin
        lfsr <= {lfsr[L-2:0], lfsr_fb};
        cnt  <= (cnt == CNT_LAST) ? '0 : cnt + L'(1);
      end
`else
      if (bus.en) begin
        lfsr <= {lfsr[L-2:0], lfsr_fb};
        cnt  <= (cnt == CNT_LAST) ? '0 : cnt + L'(1);
      end
`endif
    end
  end

  // The LFSR visits every value 1..P once per period, so the comparison is
  // true for exactly val_mag of those P cycles.
  assign hit             = bus.en & (val_mag >= lfsr);
  assign bus.y_p         = hit & ~val_sign;
  assign bus.y_m         = hit & val_sign;
  assign bus.period_done = bus.en & (cnt == CNT_LAST);

endmodule

// File: tb/tb_stoch_signed_sng.sv
// Directed bench for stoch_signed_sng (BITWIDTH=8, SEED=1, P=127).
module tb_stoch_signed_sng;

  logic CLK = 1'b0;
  logic nRST;
  int   total = 0;
  int   bad   = 0;
  logic s_p, s_m, s_pd;

  stoch_signed_sng_if #(.BITWIDTH(8)) bus ();

  stoch_signed_sng #(.BITWIDTH(8), .SEED(1)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; outputs sampled mid-cycle.
  task automatic tick(input logic e, input logic ld, input logic signed [7:0] v);
    bus.en    = e;
    bus.load  = ld;
    bus.value = v;
    #2;
    s_p  = bus.y_p;
    s_m  = bus.y_m;
    s_pd = bus.period_done;
    chk("excl", 32'(s_p & s_m), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n, input logic signed [7:0] v,
                     output int np, output int nm, output int npd,
                     output int ipd, output int first);
    np = 0; nm = 0; npd = 0; ipd = 0; first = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1'b1, 1'b0, v);
      if (i == 1) first = int'(s_p | s_m);
      np += int'(s_p);
      nm += int'(s_m);
      if (s_pd) begin
        npd++;
        ipd = i;
      end
    end
  endtask

  int np, nm, npd, ipd, first;
  int np2, nm2, npd2, ipd2, first2;
  int pause_hits;

  initial begin
    nRST      = 1'b0;
    bus.en    = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    #1;

    // reset held with en=1
    tick(1'b1, 1'b0, 8'sd0);
    tick(1'b1, 1'b0, 8'sd0);
    chk("rst_yp", 32'(s_p), 32'd0);
    chk("rst_ym", 32'(s_m), 32'd0);
    chk("rst_pd", 32'(s_pd), 32'd0);
    bus.en = 1'b0;
    nRST   = 1'b1;
    tick(1'b0, 1'b0, 8'sd0);
    chk("post_rst_out", 32'(s_p | s_m | s_pd), 32'd0);

    // +64 over one period starting right after reset
    tick(1'b0, 1'b1, 8'sd64);
    chk("load_cycle_out", 32'(s_p | s_m), 32'd0);
    run(127, 8'sd64, np, nm, npd, ipd, first);
    chk("p64_first", 32'(first), 32'd1);
    chk("p64_ones_p", 32'(np), 32'd64);
    chk("p64_ones_m", 32'(nm), 32'd0);
    chk("p64_pd_cnt", 32'(npd), 32'd1);
    chk("p64_pd_idx", 32'(ipd), 32'd127);

    // -128 saturates to magnitude 127 on the negative channel
    tick(1'b0, 1'b1, -8'sd128);
    run(127, -8'sd128, np, nm, npd, ipd, first);
    chk("m128_ones_m", 32'(nm), 32'd127);
    chk("m128_ones_p", 32'(np), 32'd0);
    chk("m128_pd_idx", 32'(ipd), 32'd127);

    // zero
    tick(1'b0, 1'b1, 8'sd0);
    run(127, 8'sd0, np, nm, npd, ipd, first);
    chk("zero_ones", 32'(np + nm), 32'd0);
    chk("zero_pd_cnt", 32'(npd), 32'd1);
    chk("zero_pd_idx", 32'(ipd), 32'd127);

    // +32 with a 10-cycle pause mid-period
    tick(1'b0, 1'b1, 8'sd32);
    run(60, 8'sd32, np, nm, npd, ipd, first);
    chk("pause_first", 32'(first), 32'd1);
    pause_hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 8'sd32);
      pause_hits += int'(s_p | s_m | s_pd);
    end
    chk("pause_out", 32'(pause_hits), 32'd0);
    run(67, 8'sd32, np2, nm2, npd2, ipd2, first2);
    chk("p32_ones_p", 32'(np + np2), 32'd32);
    chk("p32_ones_m", 32'(nm + nm2), 32'd0);
    chk("p32_pd_cnt", 32'(npd + npd2), 32'd1);
    chk("p32_pd_idx", 32'(ipd2), 32'd67);

    // load +100 on enabled cycle 50
    run(49, 8'sd32, np, nm, npd, ipd, first);
    tick(1'b1, 1'b1, 8'sd100);
    chk("ld50_pd", 32'(s_pd), 32'd0);
    run(127, 8'sd100, np, nm, npd, ipd, first);
    chk("p100_ones_p", 32'(np), 32'd100);
    chk("p100_ones_m", 32'(nm), 32'd0);
    chk("p100_pd_cnt", 32'(npd), 32'd1);
`ifdef STOCH_SNG_RESEED_ON_LOAD_EN
    chk("p100_pd_idx", 32'(ipd), 32'd127);
    chk("p100_first", 32'(first), 32'd1);
`else
    chk("p100_pd_idx", 32'(ipd), 32'd77);
`endif

    // asynchronous reset between edges
    tick(1'b0, 1'b1, 8'sd127);
    run(5, 8'sd127, np, nm, npd, ipd, first);
    chk("p127_ones_p", 32'(np), 32'd5);
    bus.en   = 1'b1;
    bus.load = 1'b0;
    #3;
    chk("pre_arst_yp", 32'(bus.y_p), 32'd1);
    nRST = 1'b0;
    #1;
    chk("arst_yp", 32'(bus.y_p), 32'd0);
    chk("arst_ym", 32'(bus.y_m), 32'd0);
    chk("arst_pd", 32'(bus.period_done), 32'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    run(127, 8'sd0, np, nm, npd, ipd, first);
    chk("after_arst_ones", 32'(np + nm), 32'd0);
    chk("after_arst_pd_idx", 32'(ipd), 32'd127);

    // load coinciding with period_done
    tick(1'b0, 1'b1, 8'sd127);
    run(126, 8'sd127, np, nm, npd, ipd, first);
    chk("pre_wrap_ones", 32'(np), 32'd126);
    tick(1'b1, 1'b1, -8'sd5);
    chk("wrap_pd", 32'(s_pd), 32'd1);
    chk("wrap_yp", 32'(s_p), 32'd1);
    run(127, -8'sd5, np, nm, npd, ipd, first);
    chk("m5_ones_m", 32'(nm), 32'd5);
    chk("m5_ones_p", 32'(np), 32'd0);
    chk("m5_pd_cnt", 32'(npd), 32'd1);
    chk("m5_pd_idx", 32'(ipd), 32'd127);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
